// File: rtl/ste_moving_avg_fir.sv
// rtl/ste_moving_avg_fir.sv - boxcar moving-average FIR for the multimeter measurement path
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   din_i          unsigned sample, taken only when din_update_i=1
//   din_update_i   sample-valid strobe, one sample per high cycle
//   dout_update_o  one-cycle strobe: dout_o has just been updated
//   dout_o         registered average of the last 2^TAPS_LOG2 samples
//
// Build option:
//   STE_AVG_ROUND_EN  defined   -> round-half-up average, saturated to 2^DATA_W-1
//                     undefined -> truncating (floor) average
module ste_moving_avg_fir #(
  parameter int DATA_W    = 16,
  parameter int TAPS_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_i,
  input  logic              din_update_i,
  output logic              dout_update_o,
  output logic [DATA_W-1:0] dout_o
);

  localparam int N     = 1 << TAPS_LOG2;
  localparam int SUM_W = DATA_W + TAPS_LOG2;

  logic [DATA_W-1:0]    win [N];
  logic [SUM_W-1:0]     sum;
  logic [SUM_W-1:0]     sum_new;
  logic [TAPS_LOG2-1:0] wr_ptr;
  logic [DATA_W-1:0]    dout_next;

  // The evicted entry is always part of sum, so the modular add/subtract
  // lands on the exact (non-negative) new window total.
  always_comb begin
    sum_new = sum + SUM_W'(din_i) - SUM_W'(win[wr_ptr]);
  end

`ifdef STE_AVG_ROUND_EN
  logic [SUM_W:0] sum_rnd;
  logic [SUM_W:0] avg_rnd;

  // One extra bit keeps the half-LSB bias from wrapping at full scale.
  always_comb begin
    sum_rnd = {1'b0, sum_new} + (SUM_W+1)'(N / 2);
    avg_rnd = sum_rnd >> TAPS_LOG2;
    if (|avg_rnd[SUM_W:DATA_W]) begin
      dout_next = '1;
    end else begin
      dout_next = avg_rnd[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    dout_next = sum_new[SUM_W-1:TAPS_LOG2];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        win[i] <= '0;
      end
      sum           <= '0;
      wr_ptr        <= '0;
      dout_o        <= '0;
      dout_update_o <= 1'b0;
    end else begin
      dout_update_o <= din_update_i;
      if (din_update_i) begin
        win[wr_ptr] <= din_i;
        wr_ptr      <= wr_ptr + TAPS_LOG2'(1);
        sum         <= sum_new;
        dout_o      <= dout_next;
      end
    end
  end

endmodule

// File: tb/tb_ste_moving_avg_fir.sv
// tb/tb_ste_moving_avg_fir.sv - scoreboard bench for ste_moving_avg_fir
module tb_ste_moving_avg_fir;

  localparam int DW = 16;
  localparam int TL = 4;
  localparam int NT = 1 << TL;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din_i;
  logic          din_update_i;
  logic          dout_update_o;
  logic [DW-1:0] dout_o;

  int errors  = 0;
  int checks  = 0;
  int strobes = 0;
  int updates = 0;
  int held    = 0;
  int exp_q[$];
  int hist[$];

  ste_moving_avg_fir #(.DATA_W(DW), .TAPS_LOG2(TL)) dut (
    .clk           (clk),
    .rst           (rst),
    .din_i         (din_i),
    .din_update_i  (din_update_i),
    .dout_update_o (dout_update_o),
    .dout_o        (dout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: average of the most recent NT samples, missing ones counted as zero.
  function automatic int model_push(input int v);
    longint total = 0;
    int avg;
    hist.push_back(v);
    if (hist.size() > NT) void'(hist.pop_front());
    foreach (hist[i]) total += hist[i];
`ifdef STE_AVG_ROUND_EN
    avg = int'((total + NT / 2) / NT);
    if (avg > 65535) avg = 65535;
`else
    avg = int'(total / NT);
`endif
    return avg;
  endfunction

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int v);
    din_i        = DW'(v);
    din_update_i = 1'b1;
    exp_q.push_back(model_push(v));
    strobes++;
    @(posedge clk);
    #1;
    din_update_i = 1'b0;
    din_i        = DW'($urandom);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    din_update_i = 1'bx;
    hist.delete();
    #20;
    check("reset_dout", int'(dout_o), 0);
    check("reset_upd", int'(dout_update_o), 0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    din_update_i = 1'b0;
    gap(2);
    check("post_reset_dout", int'(dout_o), 0);
    check("post_reset_upd", int'(dout_update_o), 0);
  endtask

  // Monitor: every strobe must match the oldest queued expectation; between
  // strobes the output must hold its last value.
  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else if (dout_update_o) begin
      updates++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("dout", int'(dout_o), e);
        held = e;
      end
    end else begin
      check("hold", int'(dout_o), held);
    end
  end

  initial begin
    din_i = '0;
    do_reset();

    // single full-scale ADC sample
    send(4095);
`ifdef STE_AVG_ROUND_EN
    check("single_4095", int'(dout_o), 256);
`else
    check("single_4095", int'(dout_o), 255);
`endif
    check("single_upd_hi", int'(dout_update_o), 1);
    gap(1);
    check("single_upd_lo", int'(dout_update_o), 0);

    // gapped ramp, then eviction of the first 1000
    do_reset();
    for (int i = 0; i < NT; i++) begin
      send(1000);
      gap(1);
    end
    check("ramp_final", int'(dout_o), 1000);
    send(2000);
`ifdef STE_AVG_ROUND_EN
    check("wrap_2000", int'(dout_o), 1063);
`else
    check("wrap_2000", int'(dout_o), 1062);
`endif
    gap(2);

    // full-scale back-to-back, then flush with zeros
    for (int i = 0; i < NT; i++) send(65535);
    check("fullscale", int'(dout_o), 65535);
    for (int i = 0; i < NT; i++) send(0);
    check("flush_zero", int'(dout_o), 0);
    gap(2);

    // random soak, mixed back-to-back and gapped
    for (int i = 0; i < 255; i++) begin
      send(int'($urandom_range(0, 4095)));
      if ($urandom_range(0, 1) == 1) gap(int'($urandom_range(1, 3)));
    end
    gap(2);

    // reset in the middle of a stream
    for (int i = 0; i < 10; i++) send(3000);
    gap(2);
    do_reset();
    send(1600);
    check("after_mid_reset", int'(dout_o), 100);
    gap(3);

    check("queue_drained", exp_q.size(), 0);
    check("strobe_count", updates, strobes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
